// File: rtl/i2s_sender_fifo.sv
// I2S transmitter with an internal stereo-frame FIFO, 1x/2x/4x sample repeat and underrun flag.
// Optional macro I2S_HOLD_LAST_EN: a starved load replays the previous frame instead of silence.
module i2s_sender_fifo #(
    parameter int unsigned SAMPLE_W     = 16,
    parameter int unsigned SLOT_W       = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned BCK_DIV      = 4,
    parameter int unsigned UNDERRUN_LIM = 3
) (
    input  logic                          i_in_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic [1:0]                    i_rate_sel,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [2*SAMPLE_W-1:0]         i_in_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_req_tick,
    output logic                          o_underrun,
    output logic                          o_bck,
    output logic                          o_lrck,
    output logic                          o_sout
);

    localparam int unsigned DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int unsigned B_W   = $clog2(2*SLOT_W);
    localparam int unsigned IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [DIV_W-1:0]      r_div;
    logic                  r_bck;
    logic [B_W-1:0]        r_b;
    logic                  r_lrck;
    logic                  r_sout;
    logic                  r_req_tick;
    logic [2*SAMPLE_W-1:0] r_frame;
    logic [1:0]            r_rep;
    logic [2:0]            r_starve;
    logic [2*SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [LVL_W-1:0]      r_level;

    logic                  w_tick;
    logic                  w_fall;
    logic                  w_load;
    logic [B_W-1:0]        w_b_next;
    logic                  w_right;
    logic [B_W-1:0]        w_k;
    logic [SAMPLE_W-1:0]   w_chan;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_bit;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_serve;
    logic                  w_pop;
    logic                  w_starve;
    logic [1:0]            w_rep_load;

    assign w_tick   = (r_div == DIV_W'(BCK_DIV - 1));
    assign w_fall   = w_tick && r_bck;
    assign w_load   = w_fall && (w_b_next == '0);
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push   = i_in_valid && o_in_ready;
    // A fresh frame is only fetched once the repeat budget of the current one is spent.
    assign w_serve  = w_load && (r_rep == '0) && i_enable;
    assign w_pop    = w_serve && !w_empty;
    assign w_starve = w_serve && w_empty;

    always_comb begin
        w_b_next = (r_b == B_W'(2*SLOT_W - 1)) ? '0 : r_b + 1'b1;
        w_right  = (w_b_next >= B_W'(SLOT_W));
        w_k      = w_right ? (w_b_next - B_W'(SLOT_W)) : w_b_next;
        w_chan   = w_right ? r_frame[SAMPLE_W-1:0] : r_frame[2*SAMPLE_W-1:SAMPLE_W];
        w_idx    = IDX_W'(SAMPLE_W - 32'(w_k));
        w_bit    = 1'b0;
        if ((w_k != '0) && (w_k <= B_W'(SAMPLE_W))) w_bit = w_chan[w_idx];
    end

    always_comb begin
        w_rep_load = 2'd3;
        case (i_rate_sel)
            2'd0:    w_rep_load = 2'd0;
            2'd1:    w_rep_load = 2'd1;
            default: w_rep_load = 2'd3;
        endcase
    end

    always_ff @(posedge i_in_clk) begin
        if (w_push) r_mem[r_wr] <= i_in_data;
    end

    always_ff @(posedge i_in_clk) begin
        if (!i_rst_n) begin
            r_div      <= '0;
            r_bck      <= 1'b0;
            r_b        <= B_W'(2*SLOT_W - 1);
            r_lrck     <= 1'b0;
            r_sout     <= 1'b0;
            r_req_tick <= 1'b0;
            r_frame    <= '0;
            r_rep      <= '0;
            r_starve   <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_level    <= '0;
        end else begin
            r_req_tick <= w_serve;

            if (w_tick) begin
                r_div <= '0;
                r_bck <= ~r_bck;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_fall) begin
                r_b    <= w_b_next;
                r_lrck <= w_right;
                r_sout <= w_bit;
            end

            if (!i_enable) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_level <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop)  r_rd <= r_rd + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end

            if (w_load) begin
                if (!i_enable) begin
                    r_frame <= '0;
                    r_rep   <= '0;
                end else if (r_rep != '0) begin
                    r_rep <= r_rep - 1'b1;
                end else if (!w_empty) begin
                    r_frame <= r_mem[r_rd];
                    r_rep   <= w_rep_load;
                end else begin
                    r_rep <= '0;
`ifdef I2S_HOLD_LAST_EN
                    r_frame <= r_frame;
`else
                    r_frame <= '0;
`endif
                end
            end

            if (!i_enable || w_pop) begin
                r_starve <= '0;
            end else if (w_starve && (r_starve != 3'd7)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign o_in_ready   = i_enable && !w_full;
    assign o_fifo_level = r_level;
    assign o_req_tick   = r_req_tick;
    assign o_underrun   = (r_starve >= 3'(UNDERRUN_LIM));
    assign o_bck        = r_bck;
    assign o_lrck       = r_lrck;
    assign o_sout       = r_sout;

endmodule
